// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Handles stall, jump/branch redirect with flush, and a terminal HALT state.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_halted, w_halted_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_is_halt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_is_halt  = (instruction[31:26] == HALT_OPCODE);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc4_nxt    = r_pc4;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    w_count_nxt  = r_count;
    unique case (r_state)
      S_RUN: begin
        if (jump) begin
          w_pc_nxt    = jump_target & ~32'd3;
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
        end else if (branch_taken) begin
          w_pc_nxt    = branch_target & ~32'd3;
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_instr_nxt = instruction;
          w_pc4_nxt   = w_pc_plus4;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count + 32'd1;
          // The halt word retires normally but the PC parks on its address.
          if (w_is_halt) begin
            w_state_nxt  = S_HALTED;
            w_halted_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      S_HALTED: begin
        w_instr_nxt = NOP_WORD;
        w_valid_nxt = 1'b0;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_WORD;
      r_pc4    <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc4    <= w_pc4_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign pc_out      = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model
// where word[i] = i+1, optionally replacing address 0x10 with a HALT word.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic        halt_en;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (halt_en && pc_out == 32'h10) instruction = 32'hFC00_0000;
    else                             instruction = {2'b00, pc_out[31:2]} + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] pc4, input logic vld, input logic [31:0] cnt);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".instr"}, if_id_instr, ins);
    check({tag, ".pc4"}, if_id_pc4, pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    check({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt_en = 1'b0;

    // 1: reset and sequential fetch
    step(); step();
    check_if("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    step(); check_if("seq1", 32'h4, 32'd1, 32'h4, 1'b1, 32'd1);
    step(); check_if("seq2", 32'h8, 32'd2, 32'h8, 1'b1, 32'd2);

    // 2: stall holds everything
    stall = 1'b1;
    step(); check_if("stall1", 32'h8, 32'd2, 32'h8, 1'b1, 32'd2);
    step(); check_if("stall2", 32'h8, 32'd2, 32'h8, 1'b1, 32'd2);
    stall = 1'b0;
    step(); check_if("unstall", 32'hC, 32'd3, 32'hC, 1'b1, 32'd3);

    // 3: branch with unaligned target, one bubble
    branch_taken = 1'b1; branch_target = 32'h43;
    step(); check_if("br", 32'h40, 32'h0, 32'hC, 1'b0, 32'd3);
    branch_taken = 1'b0;
    step(); check_if("br.tgt", 32'h44, 32'd17, 32'h44, 1'b1, 32'd4);

    // 4: jump beats branch beats stall
    jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    step(); check_if("jmp", 32'h80, 32'h0, 32'h44, 1'b0, 32'd4);
    jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    step(); check_if("jmp.tgt", 32'h84, 32'd33, 32'h84, 1'b1, 32'd5);

    // 5: halt word at 0x10
    halt_en = 1'b1; jump = 1'b1; jump_target = 32'h10;
    step(); check("h.pc0", pc_out, 32'h10);
    jump = 1'b0;
    step();
    check_if("halt", 32'h10, 32'hFC00_0000, 32'h14, 1'b1, 32'd6);
    check("halt.halted", {31'd0, halted}, 32'd1);
    step(); check_if("halted", 32'h10, 32'h0, 32'h14, 1'b0, 32'd6);
    jump = 1'b1; jump_target = 32'h80; branch_taken = 1'b1;
    step(); check_if("halted.jmp", 32'h10, 32'h0, 32'h14, 1'b0, 32'd6);
    check("halted.stay", {31'd0, halted}, 32'd1);
    jump = 1'b0; branch_taken = 1'b0; rst_n = 1'b0;
    step(); check_if("rst2", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst2.halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;

    // halt with stall retries; halt with redirect is discarded
    jump = 1'b1; jump_target = 32'h10;
    step(); jump = 1'b0; stall = 1'b1;
    step(); check_if("hstall", 32'h10, 32'h0, 32'h0, 1'b0, 32'd0);
    check("hstall.halted", {31'd0, halted}, 32'd0);
    stall = 1'b0; jump = 1'b1; jump_target = 32'h20;
    step(); check_if("hredir", 32'h20, 32'h0, 32'h0, 1'b0, 32'd0);
    check("hredir.halted", {31'd0, halted}, 32'd0);
    jump = 1'b0; halt_en = 1'b0;

    // 6: PC wrap and reset during stall
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step(); check("wrap.pc0", pc_out, 32'hFFFF_FFFC);
    jump = 1'b0;
    step(); check_if("wrap", 32'h0, 32'h4000_0000, 32'h0, 1'b1, 32'd1);
    stall = 1'b1;
    step(); check_if("wstall", 32'h0, 32'h4000_0000, 32'h0, 1'b1, 32'd1);
    step(); check_if("wstall2", 32'h0, 32'h4000_0000, 32'h0, 1'b1, 32'd1);
    stall = 1'b0;
    step(); check_if("wseq", 32'h4, 32'd1, 32'h4, 1'b1, 32'd2);
    stall = 1'b1; rst_n = 1'b0;
    step(); check_if("rst3", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst3.halted", {31'd0, halted}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
